// File: rtl/exc_ctrl_pkg.sv
// Shared exception definitions: ExcCodes, WB flag bit positions, CP0 Status/Cause fields.
package exc_ctrl_pkg;

  localparam int unsigned EXCODE_W = 5;
  localparam int unsigned FLAG_W   = 7;

  localparam logic [EXCODE_W-1:0] EX_INT  = 5'd0;
  localparam logic [EXCODE_W-1:0] EX_ADEL = 5'd4;
  localparam logic [EXCODE_W-1:0] EX_ADES = 5'd5;
  localparam logic [EXCODE_W-1:0] EX_SYS  = 5'd8;
  localparam logic [EXCODE_W-1:0] EX_BP   = 5'd9;
  localparam logic [EXCODE_W-1:0] EX_RI   = 5'd10;
  localparam logic [EXCODE_W-1:0] EX_OV   = 5'd12;

  localparam int unsigned FL_ADEL_F = 0;
  localparam int unsigned FL_RI     = 1;
  localparam int unsigned FL_SYS    = 2;
  localparam int unsigned FL_OV     = 3;
  localparam int unsigned FL_BP     = 4;
  localparam int unsigned FL_ADEL_D = 5;
  localparam int unsigned FL_ADES   = 6;

  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;
  localparam int unsigned IM_LSB = 8;
  localparam int unsigned IM_MSB = 15;

  typedef enum logic [1:0] {
    BV_ZERO,
    BV_PC,
    BV_DATA
  } bv_sel_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT
  } exc_state_e;

  typedef struct packed {
    logic                hit;
    logic [EXCODE_W-1:0] excode;
    bv_sel_e             bv_sel;
  } prio_res_t;

endpackage

// File: rtl/exc_ctrl_prio_enc.sv
// Exception priority encoder: pending interrupt and WB flags to {hit, excode, badvaddr source}.
module exc_ctrl_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic              int_req,
  input  logic [FLAG_W-1:0] flags,
  output prio_res_t         res
);

  always_comb begin
    res = '{hit: 1'b1, excode: EX_INT, bv_sel: BV_ZERO};
    if (int_req) begin
      res.excode = EX_INT;
    end else if (flags[FL_ADEL_F]) begin
      res.excode = EX_ADEL;
      res.bv_sel = BV_PC;
    end else if (flags[FL_RI]) begin
      res.excode = EX_RI;
    end else if (flags[FL_OV]) begin
      res.excode = EX_OV;
    end else if (flags[FL_SYS]) begin
      res.excode = EX_SYS;
    end else if (flags[FL_BP]) begin
      res.excode = EX_BP;
    end else if (flags[FL_ADEL_D]) begin
      res.excode = EX_ADEL;
      res.bv_sel = BV_DATA;
    end else if (flags[FL_ADES]) begin
      res.excode = EX_ADES;
      res.bv_sel = BV_DATA;
    end else begin
      res.hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// WB exception/interrupt sequencer: CP0 commit strobes, pipeline flush and fetch redirect.
// Optional EXC_STATS_EN adds exc_count/eret_count event counters.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ws_valid,
  input  logic [31:0]         ws_pc,
  input  logic                ws_bd,
  input  logic [FLAG_W-1:0]   ws_ex_flags,
  input  logic [31:0]         ws_badvaddr,
  input  logic                ws_eret,
  input  logic [31:0]         c0_status,
  input  logic [31:0]         c0_cause,
  input  logic [31:0]         c0_epc,
  input  logic                fs_redirect_ready,
  output logic                wb_ex,
  output logic [EXCODE_W-1:0] wb_excode,
  output logic                wb_bd,
  output logic [31:0]         wb_pc,
  output logic [31:0]         wb_badvaddr,
  output logic                eret_flush,
  output logic                pipe_flush,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  output logic                int_pending
`ifdef EXC_STATS_EN
  ,
  output logic [31:0]         exc_count,
  output logic [31:0]         eret_count
`endif
);

  localparam int unsigned CNT_W = 3;

  exc_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             int_req;
  logic             rst_q;
  logic             int_pend_raw;
  logic             accept;
  logic             take_ex;
  logic             take_eret;
  logic             int_taken;
  prio_res_t        prio;
  logic             unused_bits;

  assign int_pend_raw = c0_status[ST_IE] & ~c0_status[ST_EXL]
                      & (|(c0_status[IM_MSB:IM_LSB] & c0_cause[IM_MSB:IM_LSB]));
  assign unused_bits  = ^{c0_status[31:16], c0_status[7:2], c0_cause[31:16], c0_cause[7:0]};

  exc_ctrl_prio_enc u_prio (
    .int_req (int_req),
    .flags   (ws_ex_flags),
    .res     (prio)
  );

  // Strobes are suppressed in reset and the cycle after it.
  assign accept    = (state == S_IDLE) & ws_valid & ~rst & ~rst_q & (prio.hit | ws_eret);
  assign take_ex   = accept & prio.hit;
  assign take_eret = accept & ~prio.hit;
  assign int_taken = take_ex & int_req;

  assign wb_ex       = take_ex;
  assign wb_excode   = take_ex ? prio.excode : '0;
  assign wb_bd       = take_ex & ws_bd;
  assign wb_pc       = take_ex ? ws_pc : '0;
  assign wb_badvaddr = !take_ex              ? '0 :
                       (prio.bv_sel == BV_PC)   ? ws_pc :
                       (prio.bv_sel == BV_DATA) ? ws_badvaddr : '0;
  assign eret_flush  = take_eret;
  assign int_pending = int_pend_raw & ~rst & ~rst_q;

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      int_req        <= 1'b0;
      redirect_pc    <= '0;
      pipe_flush     <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      // Held across FLUSH/REDIRECT; only a quiet IDLE cycle drops it.
      if (int_taken) begin
        int_req <= 1'b0;
      end else if (int_pend_raw) begin
        int_req <= 1'b1;
      end else if (state == S_IDLE) begin
        int_req <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            state       <= S_FLUSH;
            pipe_flush  <= 1'b1;
            cnt         <= '0;
            redirect_pc <= take_ex ? EXC_VECTOR : c0_epc;
          end
        end
        S_FLUSH: begin
          if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
            state          <= S_REDIRECT;
            redirect_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_REDIRECT: begin
          if (fs_redirect_ready) begin
            state          <= S_IDLE;
            pipe_flush     <= 1'b0;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= S_IDLE;
          pipe_flush     <= 1'b0;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count  <= '0;
      eret_count <= '0;
    end else begin
      if (take_ex)   exc_count  <= exc_count + 32'd1;
      if (take_eret) eret_count <= eret_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl (default parameters; EXC_STATS_EN optional).
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic        ws_bd;
  logic [6:0]  ws_ex_flags;
  logic [31:0] ws_badvaddr;
  logic        ws_eret;
  logic [31:0] c0_status;
  logic [31:0] c0_cause;
  logic [31:0] c0_epc;
  logic        fs_redirect_ready;
  logic        wb_ex;
  logic [4:0]  wb_excode;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        eret_flush;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        int_pending;
`ifdef EXC_STATS_EN
  logic [31:0] exc_count;
  logic [31:0] eret_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .ws_valid          (ws_valid),
    .ws_pc             (ws_pc),
    .ws_bd             (ws_bd),
    .ws_ex_flags       (ws_ex_flags),
    .ws_badvaddr       (ws_badvaddr),
    .ws_eret           (ws_eret),
    .c0_status         (c0_status),
    .c0_cause          (c0_cause),
    .c0_epc            (c0_epc),
    .fs_redirect_ready (fs_redirect_ready),
    .wb_ex             (wb_ex),
    .wb_excode         (wb_excode),
    .wb_bd             (wb_bd),
    .wb_pc             (wb_pc),
    .wb_badvaddr       (wb_badvaddr),
    .eret_flush        (eret_flush),
    .pipe_flush        (pipe_flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .int_pending       (int_pending)
`ifdef EXC_STATS_EN
    ,
    .exc_count         (exc_count),
    .eret_count        (eret_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ws();
    ws_valid    = 1'b0;
    ws_pc       = '0;
    ws_bd       = 1'b0;
    ws_ex_flags = '0;
    ws_badvaddr = '0;
    ws_eret     = 1'b0;
  endtask

  task automatic present(input logic [31:0] pc, input logic bd, input logic [6:0] flags,
                         input logic eret, input logic [31:0] bva);
    ws_valid    = 1'b1;
    ws_pc       = pc;
    ws_bd       = bd;
    ws_ex_flags = flags;
    ws_eret     = eret;
    ws_badvaddr = bva;
    #2;
  endtask

  // From the accept cycle: FLUSH, REDIRECT, accept redirect, back in IDLE.
  task automatic complete();
    tick();
    clear_ws();
    tick();
    fs_redirect_ready = 1'b1;
    tick();
    fs_redirect_ready = 1'b0;
    #2;
  endtask

  initial begin
    rst               = 1'b1;
    clear_ws();
    c0_status         = '0;
    c0_cause          = '0;
    c0_epc            = '0;
    fs_redirect_ready = 1'b0;
    tick();
    tick();
    #2;
    chk("rst_wb_ex", 32'(wb_ex), 32'd0);
    chk("rst_pipe_flush", 32'(pipe_flush), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);

    // SYS offered in the cycle right after reset is not taken yet
    tick();
    rst = 1'b0;
    present(32'hBFC00100, 1'b0, 7'h04, 1'b0, 32'h0);
    chk("post_rst_no_ex", 32'(wb_ex), 32'd0);
    tick();
    #2;
    chk("sys_wb_ex", 32'(wb_ex), 32'd1);
    chk("sys_excode", 32'(wb_excode), 32'd8);
    chk("sys_wb_pc", wb_pc, 32'hBFC00100);
    chk("sys_wb_bd", 32'(wb_bd), 32'd0);
    chk("sys_badvaddr", wb_badvaddr, 32'd0);
    chk("sys_no_eret", 32'(eret_flush), 32'd0);
    chk("sys_no_flush_yet", 32'(pipe_flush), 32'd0);
    tick();
    #2;
    chk("flush_ignores_ws", 32'(wb_ex), 32'd0);
    chk("flush_pipe_flush", 32'(pipe_flush), 32'd1);
    chk("flush_no_redirect", 32'(redirect_valid), 32'd0);
    tick();
    clear_ws();
    #2;
    chk("redir_valid", 32'(redirect_valid), 32'd1);
    chk("redir_pc", redirect_pc, 32'hBFC00380);
    chk("redir_pipe_flush", 32'(pipe_flush), 32'd1);
    tick();
    #2;
    chk("redir_wait", 32'(redirect_valid), 32'd1);
    fs_redirect_ready = 1'b1;
    tick();
    fs_redirect_ready = 1'b0;
    #2;
    chk("redir_done_valid", 32'(redirect_valid), 32'd0);
    chk("redir_done_flush", 32'(pipe_flush), 32'd0);

    // ADEL_D in a delay slot
    present(32'hBFC00200, 1'b1, 7'h20, 1'b0, 32'h80000003);
    chk("adeld_excode", 32'(wb_excode), 32'd4);
    chk("adeld_bd", 32'(wb_bd), 32'd1);
    chk("adeld_badvaddr", wb_badvaddr, 32'h80000003);
    complete();

    present(32'hBFC00204, 1'b0, 7'h0E, 1'b0, 32'h0);
    chk("ri_ov_sys_excode", 32'(wb_excode), 32'd10);
    complete();

    present(32'hBFC00208, 1'b0, 7'h10, 1'b1, 32'h0);
    chk("eret_bp_excode", 32'(wb_excode), 32'd9);
    chk("eret_bp_wb_ex", 32'(wb_ex), 32'd1);
    chk("eret_bp_no_eret", 32'(eret_flush), 32'd0);
    complete();

    present(32'hBFC0020C, 1'b0, 7'h41, 1'b0, 32'h12345678);
    chk("adelf_ades_excode", 32'(wb_excode), 32'd4);
    chk("adelf_badvaddr", wb_badvaddr, 32'hBFC0020C);
    complete();

    present(32'hBFC00210, 1'b0, 7'h40, 1'b0, 32'h8000000A);
    chk("ades_excode", 32'(wb_excode), 32'd5);
    chk("ades_badvaddr", wb_badvaddr, 32'h8000000A);
    complete();

    present(32'hBFC00214, 1'b0, 7'h08, 1'b0, 32'h0);
    chk("ov_excode", 32'(wb_excode), 32'd12);
    complete();

    // ERET: target sampled at commit, held while fetch stalls
    c0_epc = 32'hBFC00724;
    present(32'hBFC00218, 1'b0, 7'h00, 1'b1, 32'h0);
    chk("eret_flush", 32'(eret_flush), 32'd1);
    chk("eret_no_ex", 32'(wb_ex), 32'd0);
    tick();
    clear_ws();
    c0_epc = 32'h0;
    tick();
    #2;
    chk("eret_redir_pc", redirect_pc, 32'hBFC00724);
    for (int i = 0; i < 5; i++) begin
      tick();
      #2;
      chk("eret_stall_valid", 32'(redirect_valid), 32'd1);
      chk("eret_stall_pc", redirect_pc, 32'hBFC00724);
    end
    fs_redirect_ready = 1'b1;
    tick();
    fs_redirect_ready = 1'b0;
    #2;
    chk("eret_idle_valid", 32'(redirect_valid), 32'd0);
    chk("eret_idle_flush", 32'(pipe_flush), 32'd0);

    // Interrupt waits for a valid WB instruction
    c0_status = 32'h00000101;
    c0_cause  = 32'h00000100;
    #2;
    chk("int_pending", 32'(int_pending), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      chk("int_no_valid", 32'(wb_ex), 32'd0);
    end
    tick();
    present(32'hBFC00300, 1'b0, 7'h00, 1'b0, 32'h0);
    chk("int_wb_ex", 32'(wb_ex), 32'd1);
    chk("int_excode", 32'(wb_excode), 32'd0);
    chk("int_wb_pc", wb_pc, 32'hBFC00300);
    tick();
    clear_ws();
    c0_status = 32'h00000103;
    #2;
    chk("int_exl_masked", 32'(int_pending), 32'd0);
    tick();
    fs_redirect_ready = 1'b1;
    tick();
    fs_redirect_ready = 1'b0;
    tick();
    present(32'hBFC00304, 1'b0, 7'h00, 1'b0, 32'h0);
    chk("exl_no_ex", 32'(wb_ex), 32'd0);
    tick();
    clear_ws();
    c0_status = '0;
    c0_cause  = '0;

    // Reset while offering a redirect
    present(32'hBFC00400, 1'b0, 7'h04, 1'b0, 32'h0);
    tick();
    clear_ws();
    tick();
    #2;
    chk("pre_rst_redirect", 32'(redirect_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("mid_rst_redirect", 32'(redirect_valid), 32'd0);
    chk("mid_rst_flush", 32'(pipe_flush), 32'd0);
    tick();

`ifdef EXC_STATS_EN
    for (int i = 0; i < 3; i++) begin
      present(32'hBFC00500 + 32'(i * 4), 1'b0, 7'h04, 1'b0, 32'h0);
      complete();
    end
    c0_epc = 32'hBFC00600;
    present(32'hBFC00510, 1'b0, 7'h00, 1'b1, 32'h0);
    complete();
    chk("exc_count", exc_count, 32'd3);
    chk("eret_count", eret_count, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
